// File: rtl/seg7_scan.sv
// Eight-digit multiplexed seven-segment driver: snapshots the digit fields once
// per scan frame and walks them across active-low anode/cathode lines.
module seg7_scan #(
  parameter int SCAN_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [47:0] digits,
  output logic [7:0]  an,
  output logic [7:0]  dec_cat,
  output logic        frame_start
);

  localparam int                CNT_W   = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       idx_q, idx_d;
  logic [47:0]      snap_q, snap_d;
  logic [7:0]       an_q, an_d;
  logic [7:0]       dec_cat_q, dec_cat_d;
  logic             frame_start_q, frame_start_d;

  logic             tick;
  logic             load;
  logic [5:0]       field;

  // Segment pattern abcdefg, 0 = lit.
  function automatic logic [6:0] seg_code(input logic [3:0] hex);
    logic [6:0] code;
    code = 7'b1111111;
    case (hex)
      4'h0: code = 7'b0000001;
      4'h1: code = 7'b1001111;
      4'h2: code = 7'b0010010;
      4'h3: code = 7'b0000110;
      4'h4: code = 7'b1001100;
      4'h5: code = 7'b0100100;
      4'h6: code = 7'b0100000;
      4'h7: code = 7'b0001111;
      4'h8: code = 7'b0000000;
      4'h9: code = 7'b0000100;
      4'hA: code = 7'b0001000;
      4'hB: code = 7'b1100000;
      4'hC: code = 7'b0110001;
      4'hD: code = 7'b1000010;
      4'hE: code = 7'b0110000;
      4'hF: code = 7'b0111000;
      default: code = 7'b1111111;
    endcase
    return code;
  endfunction

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    cnt_d         = cnt_q + CNT_W'(1);
    idx_d         = idx_q;
    snap_d        = snap_q;
    an_d          = 8'hFF;
    dec_cat_d     = 8'hFF;

    tick          = (cnt_q == CNT_MAX);
    load          = tick && (idx_q == 3'd7);
    frame_start_d = load;

    if (tick) begin
      cnt_d = '0;
      idx_d = idx_q + 3'd1;
    end

    // Snapshot only at the frame boundary so a frame never mixes old and new digits.
    if (load) snap_d = digits;

    // Outputs follow the current slot; they lag an idx change by one cycle.
    field = snap_q[6*idx_q +: 6];
    if (field[5]) begin
      an_d      = ~(8'd1 << idx_q);
      dec_cat_d = {seg_code(field[4:1]), ~field[0]};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge inputs regardless of statement order.
  // NOTE: the snapshot register is reset too, so the first frame is guaranteed blank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q         <= '0;
      idx_q         <= 3'd0;
      snap_q        <= '0;
      an_q          <= 8'hFF;
      dec_cat_q     <= 8'hFF;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      snap_q        <= snap_d;
      an_q          <= an_d;
      dec_cat_q     <= dec_cat_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign dec_cat     = dec_cat_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg7_scan.sv
// Directed bench for seg7_scan with a short prescaler; frames are checked
// cycle by cycle against a hand-entered segment table.
module tb_seg7_scan;

  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [47:0] digits = '0;
  logic [7:0]  an;
  logic [7:0]  dec_cat;
  logic        frame_start;

  int checks = 0;
  int errors = 0;

  logic [7:0] slot0_cat;
  logic [7:0] slot7_cat;

  // abcdefg, 0 = lit, indexed by hex value.
  localparam logic [6:0] SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  seg7_scan #(.SCAN_DIV(SCAN_DIV)) dut (
    .clk         (clk),
    .rst         (rst),
    .digits      (digits),
    .an          (an),
    .dec_cat     (dec_cat),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pack8(input logic [5:0] f0, input logic [5:0] f1,
                                        input logic [5:0] f2, input logic [5:0] f3,
                                        input logic [5:0] f4, input logic [5:0] f5,
                                        input logic [5:0] f6, input logic [5:0] f7);
    return {f7, f6, f5, f4, f3, f2, f1, f0};
  endfunction

  // Waits (bounded) for frame_start; returns cycles waited and how many were not blank.
  task automatic count_to_fs(output int n, output int lit);
    n   = 0;
    lit = 0;
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (an !== 8'hFF || dec_cat !== 8'hFF) lit++;
      if (frame_start === 1'b1) break;
    end
  endtask

  // Called right after a frame_start cycle; checks the 32 cycles of the frame
  // and optionally drives new digits after sample number change_at.
  task automatic run_frame(input string name, input logic [47:0] exp_d,
                           input int change_at, input logic [47:0] new_d);
    int         s;
    logic [5:0] f;
    logic [7:0] exp_an;
    logic [7:0] exp_cat;
    for (int n = 1; n <= 32; n++) begin
      @(negedge clk);
      s       = (n - 1) / 4;
      f       = exp_d[6*s +: 6];
      exp_an  = f[5] ? ~(8'd1 << s) : 8'hFF;
      exp_cat = f[5] ? {SEG[f[4:1]], ~f[0]} : 8'hFF;
      check($sformatf("%s an n%0d", name, n), {24'd0, an}, {24'd0, exp_an});
      check($sformatf("%s cat n%0d", name, n), {24'd0, dec_cat}, {24'd0, exp_cat});
      check($sformatf("%s fs n%0d", name, n), {31'd0, frame_start}, {31'd0, (n == 32)});
      if (n == 1) slot0_cat = dec_cat;
      if (n == 29) slot7_cat = dec_cat;
      if (n == change_at) digits = new_d;
    end
  endtask

  logic [47:0] d_walk, d_blank3, d_all8, d_all1, d_hex, d_coll, d_x;
  int n_wait, n_lit;

  initial begin
    for (int k = 0; k < 8; k++) d_walk[6*k +: 6] = {1'b1, 4'(k), (k == 0)};
    d_blank3 = d_walk & ~(48'd1 << 23);
    d_all8   = {8{6'h30}};
    d_all1   = {8{6'h22}};
    d_hex    = pack8({1'b1, 4'hA, 1'b0}, {1'b1, 4'hB, 1'b0}, {1'b1, 4'hC, 1'b0},
                     {1'b1, 4'hD, 1'b0}, {1'b1, 4'hE, 1'b0}, {1'b1, 4'hF, 1'b0},
                     {1'b1, 4'h9, 1'b0}, {1'b1, 4'h2, 1'b0});
    d_coll   = pack8({1'b1, 4'h3, 1'b1}, {1'b1, 4'h4, 1'b0}, {1'b1, 4'h5, 1'b1},
                     {1'b1, 4'h6, 1'b0}, {1'b1, 4'h7, 1'b1}, {1'b1, 4'h0, 1'b0},
                     {1'b1, 4'h1, 1'b1}, {1'b1, 4'h2, 1'b0});
    d_x      = {8{6'b1_1111_1}};

    // Power-on reset.
    #2 rst = 1'b0;
    #1;
    check("rst an", {24'd0, an}, 32'h0000_00FF);
    check("rst cat", {24'd0, dec_cat}, 32'h0000_00FF);
    check("rst fs", {31'd0, frame_start}, 32'd0);
    repeat (3) @(negedge clk);
    digits = d_walk;
    rst    = 1'b1;

    count_to_fs(n_wait, n_lit);
    check("first fs latency", n_wait, 32'd32);
    check("first frame blank", n_lit, 32'd0);

    run_frame("walk", d_walk, 5, d_blank3);
    check("walk slot0 cat", {24'd0, slot0_cat}, 32'h0000_0002);
    check("walk slot7 cat", {24'd0, slot7_cat}, 32'h0000_001F);

    run_frame("blank3", d_blank3, 2, d_all8);
    // Switch to all-1 during slot 4; the all-8 frame must stay intact.
    run_frame("tear8", d_all8, 18, d_all1);
    run_frame("tear1", d_all1, 3, d_hex);
    // Change lands on the tick cycle with idx==7: captured by this frame's snapshot edge.
    run_frame("hex", d_hex, 31, d_coll);
    // Change just after the snapshot edge must wait a full frame.
    run_frame("coll", d_coll, 32, d_x);
    run_frame("coll_hold", d_coll, 0, d_x);

    // Mid-frame async reset while slot 5 is shown.
    repeat (21) @(negedge clk);
    check("slot5 an before rst", {24'd0, an}, 32'h0000_00DF);
    #2 rst = 1'b0;
    #1;
    check("async rst an", {24'd0, an}, 32'h0000_00FF);
    check("async rst cat", {24'd0, dec_cat}, 32'h0000_00FF);
    check("async rst fs", {31'd0, frame_start}, 32'd0);
    repeat (2) @(negedge clk);
    check("held rst an", {24'd0, an}, 32'h0000_00FF);
    rst = 1'b1;

    count_to_fs(n_wait, n_lit);
    check("post rst fs latency", n_wait, 32'd32);
    check("post rst frame blank", n_lit, 32'd0);
    run_frame("post_rst", d_x, 0, d_x);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan.md
# seg7_scan

Multiplexed 8-digit seven-segment display driver that sits directly downstream of the sequence-generator core inside `top`. The core presents eight display digits. This block latches them once per scan frame, so the display shows no tearing. It then time-multiplexes the digits onto the board's active-low anode (`an`) and cathode (`dec_cat`) lines at a refresh rate set by a prescaler.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot; legal range 2..2^20. Simulation benches use 4.
- `clk` input 1: system clock, 100 MHz.
- `rst` input 1: asynchronous, active-low reset.
- `digits` input 48: eight packed digit fields. Digit k occupies `digits[6k+5:6k]` = {en, hex[3:0], dp}. Digit 0 is the rightmost.
- `an` output 8: anode enables, active low. `an[k]` drives digit k.
- `dec_cat` output 8: cathodes, active low. Bits [7:1] are segments a..g; bit [0] is the decimal point.
- `frame_start` output 1: one-cycle pulse marking a new snapshot load.

## Operation
- Prescaler `cnt` counts 0..SCAN_DIV-1 and wraps to 0. The tick condition is `cnt==SCAN_DIV-1`.
- On each tick edge:
  - Slot index `idx` (3 bits) increments, wrapping 7→0.
  - If `idx==7` on that tick, snapshot register `snap` ← `digits`, and `frame_start` is 1 for the following cycle.
  - `frame_start` is 0 in every other cycle.
- Outputs are registered every cycle from (`idx`, `snap`) for the field f = `snap[6·idx+5 : 6·idx]`:
  - f.en=1: `an` = ~(1<<idx); `dec_cat[7:1]` = segment code of f.hex; `dec_cat[0]` = ~f.dp.
  - f.en=0: `an` = 8'hFF and `dec_cat` = 8'hFF, meaning slot blanked.
- Segment code table, abcdefg, 0 = lit:
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110
  - 4=1001100, 5=0100100, 6=0100000, 7=0001111
  - 8=0000000, 9=0000100, A=0001000, b=1100000
  - C=0110001, d=1000010, E=0110000, F=0111000
- `digits` changes outside the snapshot edge have no visible effect until the next frame.
- The snapshot loads when the tick and `idx==7` coincide, even if `digits` changes in that same cycle. The value sampled is the one present at that edge.

## Timing
- Reset (`rst`=0, asynchronous, effective immediately):
  - `cnt`=0, `idx`=0, `snap`=0.
  - `an`=8'hFF, `dec_cat`=8'hFF, `frame_start`=0.
  - Reset asserted mid-frame aborts the frame with no partial output.
- After reset release, the first tick occurs at the edge ending cycle SCAN_DIV (cnt 0..SCAN_DIV-1). The first snapshot loads on the 8th tick, i.e. 8·SCAN_DIV cycles after release. The display is blank for the whole first frame because `snap`=0.
- Latency:
  - `idx` updates at the tick edge.
  - `an`/`dec_cat` reflect the new `idx` at the next edge, one cycle later.
  - A new snapshot appears on slot 0 outputs one cycle after `frame_start` rises.
- Each slot is SCAN_DIV cycles long and each frame is 8·SCAN_DIV cycles. With the default at 100 MHz, each digit refreshes at 125 Hz.
- Exactly one `an` bit is low in any cycle, or none when the slot is blanked or in reset.

## Test plan
- **Async reset:** with SCAN_DIV=4, assert `rst`=0 while the outputs show digit 5. Required response: in the same timestep `an`=FF and `dec_cat`=FF. After release, `frame_start` first pulses 32 cycles later.
- **Full frame:** set `digits` to digit k = {1, k, k==0}. In the frame after the first `frame_start`, `an` walks FE,FD,FB,…,7F, holding each value 4 cycles. Slot 0 `dec_cat`=0000001_0 and slot 7 `dec_cat`=0001111_1.
- **Blanking:** clear en on digit 3 only. During slot 3, `an`=FF and `dec_cat`=FF; all other slots are unaffected.
- **No tearing:** change `digits` from all-8 to all-1 during slot 4. The rest of the frame shows 0000000 on every slot. After the next `frame_start`, every slot shows 1001111.
- **Hex coverage:** load A,b,C,d,E,F,9,2 across slots 0..7 with dp off. The observed codes must match the table and `dec_cat[0]` must be 1 on every slot.
- **Snapshot edge collision:** change `digits` exactly on the tick cycle with `idx==7`. The new value appears at slot 0 of the following frame.
